// File: rtl/alu_sequencer.sv
// alu_sequencer: takes one ALU command at a time, waits SETTLE cycles, then returns the sampled result.
module alu_sequencer #(
  parameter int SETTLE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic        cmd_cin,
  input  logic        cmd_chain,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_sel,
  output logic        alu_cin,
  input  logic [7:0]  alu_out,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_overflow,
  output logic [2:0]  rsp_op,
  output logic [15:0] op_count
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic [2:0] r_cnt;
  logic [7:0] r_acc;
  logic w_accept, w_capture, w_rsp_hs;
  always_comb begin
    w_accept  = cmd_valid && cmd_ready;
    w_capture = r_state == WAIT && r_cnt == 3'd0;
    rsp_valid = r_state == RESP;
    w_rsp_hs  = rsp_valid && rsp_ready;
    w_next    = (r_state == IDLE && w_accept)  ? WAIT :
                (r_state == WAIT && w_capture) ? RESP :
                (r_state == RESP && w_rsp_hs)  ? IDLE : r_state;
  end
  // cmd_ready is registered so it stays low until reset has been sampled low
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      cmd_ready <= 1'b0;
    end else begin
      r_state   <= w_next;
      cmd_ready <= w_next == IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_sel      <= '0;
      alu_cin      <= 1'b0;
      rsp_data     <= '0;
      rsp_overflow <= 1'b0;
      rsp_op       <= '0;
      op_count     <= '0;
    end else begin
      if (w_accept) begin
        alu_a   <= cmd_chain ? r_acc : cmd_a;
        alu_b   <= cmd_b;
        alu_sel <= cmd_op;
        alu_cin <= cmd_cin;
        r_cnt   <= 3'(SETTLE - 1);
      end else if (r_state == WAIT && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
      // overflow only means something for add/sub; the select also masks any X from the ALU
      if (w_capture) begin
        rsp_data     <= alu_out;
        rsp_op       <= alu_sel;
        rsp_overflow <= (alu_sel[2:1] == 2'b00) ? alu_overflow : 1'b0;
      end
      if (w_rsp_hs) begin
        r_acc    <= rsp_data;
        op_count <= op_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of alu_sequencer against a behavioural ALU model.
module tb_alu_sequencer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_cin = 1'b0, cmd_chain = 1'b0, rsp_ready = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  cmd_a = '0, cmd_b = '0;
  logic        cmd_ready, alu_cin, alu_overflow, rsp_valid, rsp_overflow;
  logic [7:0]  alu_a, alu_b, alu_out, rsp_data;
  logic [2:0]  alu_sel, rsp_op;
  logic [15:0] op_count;
  logic        ovf_x = 1'b0;
  logic [8:0]  m_sum, m_dif;
  logic        s4_valid = 1'b0, s4_rsp_ready = 1'b0, s4_ovf_in = 1'b0;
  logic [7:0]  s4_out_in = '0;
  logic        s4_ready, s4_cin, s4_rsp_valid, s4_rsp_ovf;
  logic [7:0]  s4_a, s4_b, s4_rsp_data;
  logic [2:0]  s4_sel, s4_rsp_op;
  logic [15:0] s4_count;
  int          n_vec = 0, n_err = 0;
  logic [15:0] exp_cnt = '0;
  always #5 clock = ~clock;
  alu_sequencer #(.SETTLE(1)) u_dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_overflow(alu_overflow), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_overflow(rsp_overflow), .rsp_op(rsp_op), .op_count(op_count)
  );
  alu_sequencer #(.SETTLE(4)) u_dut4 (
    .clock(clock), .reset(reset), .cmd_valid(s4_valid), .cmd_ready(s4_ready),
    .cmd_op(3'b000), .cmd_a(8'h01), .cmd_b(8'h01), .cmd_cin(1'b0), .cmd_chain(1'b0),
    .alu_a(s4_a), .alu_b(s4_b), .alu_sel(s4_sel), .alu_cin(s4_cin),
    .alu_out(s4_out_in), .alu_overflow(s4_ovf_in), .rsp_valid(s4_rsp_valid), .rsp_ready(s4_rsp_ready),
    .rsp_data(s4_rsp_data), .rsp_overflow(s4_rsp_ovf), .rsp_op(s4_rsp_op), .op_count(s4_count)
  );
  // behavioural ALU; overflow is meaningless outside add/sub, so drive X or 1 there
  always_comb begin
    m_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
    m_dif = {1'b0, alu_a} - {1'b0, alu_b};
    alu_out = alu_sel == 3'b000 ? m_sum[7:0] : alu_sel == 3'b001 ? m_dif[7:0] :
              alu_sel == 3'b010 ? (alu_a & alu_b) : alu_sel == 3'b011 ? (alu_a | alu_b) :
              alu_sel == 3'b100 ? (alu_a ^ alu_b) : alu_sel == 3'b101 ? ~alu_a :
              alu_sel == 3'b110 ? {alu_a[6:0], 1'b0} : {1'b0, alu_a[7:1]};
    alu_overflow = alu_sel == 3'b000 ? m_sum[8] : alu_sel == 3'b001 ? m_dif[8] : (ovf_x ? 1'bx : 1'b1);
  end
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic op_issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic chain, input logic [7:0] exp_a,
                          input logic [7:0] exp_d, input logic exp_o);
    @(negedge clock);
    chk("ready_idle", 16'(cmd_ready), 16'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_chain = chain;
    @(negedge clock);
    cmd_valid = 1'b0; cmd_a = 8'h5A; cmd_b = 8'hC3; cmd_op = ~op; cmd_chain = 1'b0;
    chk("alu_a", 16'(alu_a), 16'(exp_a));
    chk("alu_sel", 16'(alu_sel), 16'(op));
    chk("ready_wait", 16'(cmd_ready), 16'd0);
    chk("valid_wait", 16'(rsp_valid), 16'd0);
    @(negedge clock);
    chk("rsp_valid", 16'(rsp_valid), 16'd1);
    chk("rsp_data", 16'(rsp_data), 16'(exp_d));
    chk("rsp_ovf", 16'(rsp_overflow), 16'(exp_o));
    chk("rsp_op", 16'(rsp_op), 16'(op));
    chk("ready_resp", 16'(cmd_ready), 16'd0);
  endtask
  task automatic op_done();
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    chk("valid_after_hs", 16'(rsp_valid), 16'd0);
    chk("ready_after_hs", 16'(cmd_ready), 16'd1);
    chk("op_count", op_count, exp_cnt);
  endtask
  initial begin
    repeat (3) @(negedge clock);
    chk("rst_ready", 16'(cmd_ready), 16'd0);
    chk("rst_valid", 16'(rsp_valid), 16'd0);
    chk("rst_count", op_count, 16'd0);
    chk("rst_alu_a", 16'(alu_a), 16'd0);
    reset = 1'b0;
    chk("ready_before_sample", 16'(cmd_ready), 16'd0);
    op_issue(3'b000, 8'h01, 8'h00, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0); op_done();
    op_issue(3'b001, 8'h01, 8'hAA, 1'b0, 1'b0, 8'h01, 8'h57, 1'b1); op_done();
    ovf_x = 1'b1;
    op_issue(3'b010, 8'hA0, 8'hFF, 1'b0, 1'b0, 8'hA0, 8'hA0, 1'b0); op_done();
    ovf_x = 1'b0;
    op_issue(3'b100, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'h0F, 8'hFF, 1'b0); op_done();
    op_issue(3'b000, 8'hFF, 8'h01, 1'b1, 1'b0, 8'hFF, 8'h01, 1'b1); op_done();
    op_issue(3'b101, 8'h5A, 8'h00, 1'b0, 1'b0, 8'h5A, 8'hA5, 1'b0); op_done();
    op_issue(3'b110, 8'hC3, 8'h00, 1'b0, 1'b0, 8'hC3, 8'h86, 1'b0); op_done();
    op_issue(3'b111, 8'h81, 8'h00, 1'b0, 1'b0, 8'h81, 8'h40, 1'b0); op_done();
    op_issue(3'b011, 8'h12, 8'h21, 1'b0, 1'b0, 8'h12, 8'h33, 1'b0); op_done();
    op_issue(3'b000, 8'h03, 8'h04, 1'b0, 1'b0, 8'h03, 8'h07, 1'b0); op_done();
    op_issue(3'b000, 8'hFF, 8'h05, 1'b0, 1'b1, 8'h07, 8'h0C, 1'b0); op_done();
    // backpressure with stray command pulses that must be dropped
    op_issue(3'b000, 8'h02, 8'h02, 1'b0, 1'b0, 8'h02, 8'h04, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = i[0]; cmd_a = 8'h99; cmd_op = 3'b100;
      @(negedge clock);
      chk("bp_valid", 16'(rsp_valid), 16'd1);
      chk("bp_data", 16'(rsp_data), 16'h04);
      chk("bp_ready", 16'(cmd_ready), 16'd0);
      chk("bp_count", op_count, exp_cnt);
      chk("bp_alu_a", 16'(alu_a), 16'h02);
    end
    cmd_valid = 1'b0;
    op_done();
    // reset abandons an operation in WAIT and clears the accumulator
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 8'h10; cmd_b = 8'h10;
    @(negedge clock);
    cmd_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_valid", 16'(rsp_valid), 16'd0);
    chk("mid_rst_alu_a", 16'(alu_a), 16'd0);
    chk("mid_rst_data", 16'(rsp_data), 16'd0);
    chk("mid_rst_count", op_count, 16'd0);
    chk("mid_rst_ready", 16'(cmd_ready), 16'd0);
    reset = 1'b0; exp_cnt = '0;
    @(negedge clock);
    chk("post_rst_valid", 16'(rsp_valid), 16'd0);
    op_issue(3'b000, 8'hEE, 8'h09, 1'b0, 1'b1, 8'h00, 8'h09, 1'b0); op_done();
    @(negedge clock);
    force u_dut.op_count = 16'hFFFF;
    #1 release u_dut.op_count;
    exp_cnt = 16'hFFFF;
    op_issue(3'b000, 8'h01, 8'h01, 1'b0, 1'b0, 8'h01, 8'h02, 1'b0); op_done();
    // SETTLE=4 instance: only the value present at the fourth edge is returned
    @(negedge clock);
    chk("s4_ready", 16'(s4_ready), 16'd1);
    s4_valid = 1'b1; s4_out_in = 8'h11;
    @(negedge clock);
    s4_valid = 1'b0;
    chk("s4_t0_valid", 16'(s4_rsp_valid), 16'd0);
    @(negedge clock);
    s4_out_in = 8'h22;
    chk("s4_t1_valid", 16'(s4_rsp_valid), 16'd0);
    @(negedge clock);
    s4_out_in = 8'h33;
    chk("s4_t2_valid", 16'(s4_rsp_valid), 16'd0);
    @(negedge clock);
    s4_out_in = 8'h44;
    chk("s4_t3_valid", 16'(s4_rsp_valid), 16'd0);
    @(negedge clock);
    s4_out_in = 8'h55;
    chk("s4_t4_valid", 16'(s4_rsp_valid), 16'd1);
    chk("s4_t4_data", 16'(s4_rsp_data), 16'h44);
    @(negedge clock);
    chk("s4_hold_data", 16'(s4_rsp_data), 16'h44);
    s4_rsp_ready = 1'b1;
    @(negedge clock);
    s4_rsp_ready = 1'b0;
    chk("s4_count", s4_count, 16'd1);
    chk("s4_ready_after", 16'(s4_ready), 16'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

- Command-side initiator for the 8-bit ALU datapath.
- Accepts one operation request at a time over a valid/ready handshake and drives the ALU operand, select and carry-in buses.
- Waits a programmable settle interval, then samples the ALU result and overflow.
- Returns them over a second valid/ready handshake.
- Keeps an accumulator of the last delivered result so operations can be chained, and counts completed operations.

## Interface
Parameters:
- SETTLE, 1: cycles between driving the ALU buses and sampling `alu_out`. Legal range 1..7; 0 is illegal.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  operation code:
  - 000 add, 001 sub, 010 and, 011 or
  - 100 xor, 101 not A, 110 shl A, 111 shr A
- cmd_a  in  8  operand A; ignored when `cmd_chain`=1
- cmd_b  in  8  operand B
- cmd_cin  in  1  carry-in for add
- cmd_chain  in  1  use the accumulator as operand A
- alu_a  out  8  ALU operand A
- alu_b  out  8  ALU operand B
- alu_sel  out  3  ALU output select; equals the latched `cmd_op`
- alu_cin  out  1  ALU adder carry-in
- alu_out  in  8  ALU result
- alu_overflow  in  1  ALU overflow/carry-out
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  8  captured result
- rsp_overflow  out  1  captured overflow
- rsp_op  out  3  op code of this response
- op_count  out  16  number of completed responses, modulo 2^16

## Operation
States: IDLE, WAIT, RESP.

IDLE:
- `cmd_ready`=1.
- On `cmd_valid`&&`cmd_ready`, register the ALU buses:
  - `alu_a` = `cmd_chain` ? acc : `cmd_a`
  - `alu_b` = `cmd_b`, `alu_sel` = `cmd_op`, `alu_cin` = `cmd_cin`
- Load settle counter = SETTLE-1; go to WAIT.

WAIT:
- `cmd_ready`=0.
- Counter nonzero: decrement.
- Counter zero: on that edge capture `rsp_data`=`alu_out` and `rsp_op`=`alu_sel`.
  - `rsp_overflow` = `alu_overflow` when `alu_sel` is 000 or 001, else 0. This forces any X from the ALU to 0.
- Then go to RESP.

RESP:
- `rsp_valid`=1; `rsp_data`, `rsp_overflow` and `rsp_op` are held stable.
- On `rsp_valid`&&`rsp_ready`:
  - acc ← `rsp_data`
  - `op_count` ← `op_count`+1, wrapping 0xFFFF→0x0000
  - go to IDLE

General rules:
- acc is internal, 8 bits, reset to 0x00. It is updated only at response handshake, never at capture.
- `alu_*` outputs change only on a command-accept edge. They hold their last value through WAIT, RESP and IDLE.
- `cmd_*` inputs are sampled only on the accept edge; later changes have no effect.
- One operation is in flight at most; no buffering of commands or responses.

## Timing
- Reset (`reset`=1 at an edge):
  - state=IDLE, acc=0, settle counter=0
  - all outputs 0, including `cmd_ready`=0 while `reset` is high
  - `cmd_ready`=1 from the first cycle after `reset` is sampled low
- Reset mid-operation (WAIT or RESP):
  - the operation is abandoned and no response is issued
  - `op_count` and acc clear; reset takes priority over all handshakes
- Latency, with accept at edge t:
  - `alu_*` valid after t
  - capture at edge t+SETTLE
  - `rsp_valid` high after t+SETTLE
- Minimum command-to-command period is SETTLE+2 cycles, reached with `rsp_ready` held high.
- A command and a response handshake never occur on the same edge. `cmd_ready` stays 0 in the cycle `rsp_valid`&&`rsp_ready` completes.
- Backpressure: `rsp_ready`=0 holds RESP indefinitely with outputs stable. `cmd_ready` stays 0 and `op_count` stays unchanged.
- `cmd_valid` asserted outside IDLE is ignored, not queued.

## Test plan
Bench pairs the block with a behavioural ALU model; SETTLE=1 unless stated.

- Add: A=00000001, B=00000000, cin=0, op=000, accepted at edge t → `alu_sel`=000 after t; `rsp_valid`=1 after t+1 with `rsp_data`=00000001, `rsp_overflow`=0, `rsp_op`=000; `op_count`=1 after handshake.
- Sub/and/overflow masking: A=00000001, B=10101010, op=001 → `rsp_data`=01010111, `rsp_overflow` = model `alu_overflow`. Then A=10100000, op=010, model drives `alu_overflow`=x → `rsp_data`=10100000, `rsp_overflow`=0.
- Chaining: add 3+4, then `cmd_chain`=1 add B=5 with `cmd_a`=0xFF → second op drives `alu_a`=7; `rsp_data`=12 (00001100).
- Backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid` → `rsp_data` stable, `cmd_ready`=0, `op_count` unchanged, `cmd_valid` pulses ignored; release → one handshake, `cmd_ready`=1 the following cycle.
- SETTLE=4: accept at t → no capture before edge t+4. A change of model `alu_out` at t+2 is not visible; the value present at edge t+4 is returned.
- Reset and wrap:
  - reset asserted in WAIT → no `rsp_valid`, all outputs 0, acc=0
  - preload 65535 completions (or force the counter) → next completion yields `op_count`=0
